// File: rtl/combination_lock_programmer.sv
// Writer side of the combination lock: holds the three codes the lock compares
// against and replaces them after a matching entry/confirmation sequence.
module combination_lock_programmer #(
    parameter logic [3:0] DEFAULT_CODE0  = 4'b1101,
    parameter logic [3:0] DEFAULT_CODE1  = 4'b0111,
    parameter logic [3:0] DEFAULT_CODE2  = 4'b1001,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TIMER_WIDTH    = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Unlocked,
    input  logic       Prog,
    input  logic       Enter,
    input  logic [3:0] Password,
    output logic [3:0] Code0,
    output logic [3:0] Code1,
    output logic [3:0] Code2,
    output logic [2:0] state,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_E0     = 3'd1,
        S_E1     = 3'd2,
        S_E2     = 3'd3,
        S_C0     = 3'd4,
        S_C1     = 3'd5,
        S_C2     = 3'd6,
        S_COMMIT = 3'd7
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             pend0_q, pend0_d, pend1_q, pend1_d, pend2_q, pend2_d;
    logic [3:0]             code0_q, code0_d, code1_q, code1_d, code2_q, code2_d;
    logic                   mismatch_q, mismatch_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   done_q, done_d, error_q, error_d;
    logic                   go_idle;
    logic                   final_mismatch;

    always_comb begin
        state_d        = state_q;
        pend0_d        = pend0_q;
        pend1_d        = pend1_q;
        pend2_d        = pend2_q;
        code0_d        = code0_q;
        code1_d        = code1_q;
        code2_d        = code2_q;
        mismatch_d     = mismatch_q;
        timer_d        = timer_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        go_idle        = 1'b0;
        final_mismatch = mismatch_q | (Password != pend2_q);

        case (state_q)
            S_IDLE: begin
                if (Prog && Unlocked) begin
                    state_d = S_E0;
                    timer_d = '0;
                end
            end
            S_COMMIT: begin
                go_idle = 1'b1;
            end
            default: begin
                // Abort outranks Enter, which outranks the inactivity timeout.
                if (!Unlocked) begin
                    go_idle = 1'b1;
                    error_d = 1'b1;
                end else if (Enter) begin
                    timer_d = '0;
                    case (state_q)
                        S_E0: begin pend0_d = Password; state_d = S_E1; end
                        S_E1: begin pend1_d = Password; state_d = S_E2; end
                        S_E2: begin pend2_d = Password; state_d = S_C0; end
                        S_C0: begin
                            if (Password != pend0_q) mismatch_d = 1'b1;
                            state_d = S_C1;
                        end
                        S_C1: begin
                            if (Password != pend1_q) mismatch_d = 1'b1;
                            state_d = S_C2;
                        end
                        S_C2: begin
                            // Codes land together with Done, while COMMIT is occupied.
                            mismatch_d = final_mismatch;
                            state_d    = S_COMMIT;
                            if (final_mismatch) begin
                                error_d = 1'b1;
                            end else begin
                                code0_d = pend0_q;
                                code1_d = pend1_q;
                                code2_d = pend2_q;
                                done_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (timer_q == TIMER_LAST) begin
                    go_idle = 1'b1;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
        endcase

        if (go_idle) begin
            state_d    = S_IDLE;
            pend0_d    = 4'd0;
            pend1_d    = 4'd0;
            pend2_d    = 4'd0;
            mismatch_d = 1'b0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            pend0_q    <= 4'd0;
            pend1_q    <= 4'd0;
            pend2_q    <= 4'd0;
            code0_q    <= DEFAULT_CODE0;
            code1_q    <= DEFAULT_CODE1;
            code2_q    <= DEFAULT_CODE2;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            code0_q    <= code0_d;
            code1_q    <= code1_d;
            code2_q    <= code2_d;
            mismatch_q <= mismatch_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign Code0 = code0_q;
    assign Code1 = code1_q;
    assign Code2 = code2_q;
    assign state = state_q;
    assign Busy  = (state_q != S_IDLE);
    assign Done  = done_q;
    assign Error = error_q;

endmodule

// File: tb/tb_combination_lock_programmer.sv
// Self-checking bench for combination_lock_programmer: directed scenarios plus
// randomized traffic against a sequence-level reference model.
module tb_combination_lock_programmer;

    localparam int TIMEOUT = 1000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Unlocked = 1'b0;
    logic       Prog = 1'b0;
    logic       Enter = 1'b0;
    logic [3:0] Password = 4'd0;
    logic [3:0] Code0, Code1, Code2;
    logic [2:0] state;
    logic       Busy, Done, Error;

    int n_checks = 0;
    int n_fail   = 0;

    combination_lock_programmer dut (
        .Clk(Clk), .Reset(Reset), .Unlocked(Unlocked), .Prog(Prog), .Enter(Enter),
        .Password(Password), .Code0(Code0), .Code1(Code1), .Code2(Code2),
        .state(state), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    // Reference model: phase counts codes typed so far (0 idle, 7 commit cycle);
    // the typed codes are kept in a list and the two halves compared at the end.
    int         m_phase = 0;
    int         m_idle  = 0;
    logic [3:0] m_code[3];
    logic [3:0] m_ent[$];
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;

    task automatic model_step(input logic p, input logic e, input logic [3:0] pw,
                              input logic u, input logic r);
        bit same;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_phase = 0; m_idle = 0; m_ent.delete();
            m_code[0] = 4'b1101; m_code[1] = 4'b0111; m_code[2] = 4'b1001;
        end else if (m_phase == 0) begin
            if (p && u) begin m_phase = 1; m_idle = 0; m_ent.delete(); end
        end else if (m_phase == 7) begin
            m_phase = 0; m_ent.delete();
        end else if (!u) begin
            m_phase = 0; m_err = 1'b1; m_ent.delete();
        end else if (e) begin
            m_ent.push_back(pw);
            m_idle = 0;
            if (m_phase == 6) begin
                same = 1;
                for (int i = 0; i < 3; i++) if (m_ent[i] != m_ent[i+3]) same = 0;
                if (same) begin
                    for (int i = 0; i < 3; i++) m_code[i] = m_ent[i];
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_phase = 7;
            end else begin
                m_phase++;
            end
        end else if (m_idle == TIMEOUT - 1) begin
            m_phase = 0; m_err = 1'b1; m_idle = 0; m_ent.delete();
        end else begin
            m_idle++;
        end
    endtask

    task automatic tick(input logic p, input logic e, input logic [3:0] pw,
                        input logic u, input logic r);
        Prog = p; Enter = e; Password = pw; Unlocked = u; Reset = r;
        @(posedge Clk);
        model_step(p, e, pw, u, r);
        #1;
        Prog = 1'b0; Enter = 1'b0; Reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 0, 4'h0, 0, 1);
        tick(0, 0, 4'h0, 0, 1);
        n_checks++;
        if ({Code0, Code1, Code2} !== 12'b1101_0111_1001) begin
            n_fail++; $display("FAIL reset_codes: got %h expected %h", {Code0, Code1, Code2}, 12'b1101_0111_1001);
        end
        n_checks++;
        if ({state, Busy, Done, Error} !== 6'b000_000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", {state, Busy, Done, Error}, 6'b0);
        end
    endtask

    task automatic test_program();
        logic [3:0] seq[6] = '{4'b0011, 4'b0101, 4'b1110, 4'b0011, 4'b0101, 4'b1110};
        tick(1, 0, 4'h0, 1, 0);
        n_checks++;
        if (state !== 3'd1 || Busy !== 1'b1) begin
            n_fail++; $display("FAIL prog_enter_e0: got state %0d busy %b expected 1 1", state, Busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 4'h0, 1, 0);
            tick(0, 1, seq[i], 1, 0);
        end
        n_checks++;
        if (Done !== 1'b1 || Error !== 1'b0 || state !== 3'd7) begin
            n_fail++; $display("FAIL prog_done: got done %b err %b state %0d expected 1 0 7", Done, Error, state);
        end
        n_checks++;
        if ({Code0, Code1, Code2} !== 12'b0011_0101_1110) begin
            n_fail++; $display("FAIL prog_codes: got %h expected %h", {Code0, Code1, Code2}, 12'b0011_0101_1110);
        end
        tick(0, 0, 4'h0, 1, 0);
        n_checks++;
        if (Done !== 1'b0 || state !== 3'd0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL prog_after: got done %b state %0d busy %b expected 0 0 0", Done, state, Busy);
        end
    endtask

    task automatic test_mismatch();
        logic [3:0] seq[6] = '{4'b0011, 4'b0101, 4'b1110, 4'b0011, 4'b0101, 4'b0100};
        tick(1, 0, 4'h0, 1, 0);
        for (int i = 0; i < 6; i++) tick(0, 1, seq[i], 1, 0);
        n_checks++;
        if (Error !== 1'b1 || Done !== 1'b0) begin
            n_fail++; $display("FAIL mismatch_pulse: got err %b done %b expected 1 0", Error, Done);
        end
        n_checks++;
        if ({Code0, Code1, Code2} !== 12'b0011_0101_1110) begin
            n_fail++; $display("FAIL mismatch_codes: got %h expected %h", {Code0, Code1, Code2}, 12'b0011_0101_1110);
        end
        tick(0, 0, 4'h0, 1, 0);
        n_checks++;
        if (Error !== 1'b0 || state !== 3'd0) begin
            n_fail++; $display("FAIL mismatch_after: got err %b state %0d expected 0 0", Error, state);
        end
    endtask

    task automatic test_timeout();
        tick(1, 0, 4'h0, 1, 0);
        tick(0, 1, 4'h1, 1, 0);
        tick(0, 1, 4'h2, 1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 4'h0, 1, 0);
        n_checks++;
        if (state !== 3'd3 || Error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got state %0d err %b expected 3 0", state, Error);
        end
        tick(0, 0, 4'h0, 1, 0);
        n_checks++;
        if (state !== 3'd0 || Error !== 1'b1) begin
            n_fail++; $display("FAIL timeout_fire: got state %0d err %b expected 0 1", state, Error);
        end
        n_checks++;
        if ({Code0, Code1, Code2} !== 12'b0011_0101_1110) begin
            n_fail++; $display("FAIL timeout_codes: got %h expected %h", {Code0, Code1, Code2}, 12'b0011_0101_1110);
        end
        tick(1, 0, 4'h0, 1, 0);
        tick(0, 1, 4'h1, 1, 0);
        tick(0, 1, 4'h2, 1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 4'h0, 1, 0);
        tick(0, 1, 4'h3, 1, 0);
        n_checks++;
        if (state !== 3'd4 || Error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_saved: got state %0d err %b expected 4 0", state, Error);
        end
        tick(0, 0, 4'h0, 0, 0);
    endtask

    task automatic test_abort();
        tick(0, 0, 4'h0, 1, 0);
        tick(1, 0, 4'h0, 1, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 4'(i), 1, 0);
        n_checks++;
        if (state !== 3'd5) begin
            n_fail++; $display("FAIL abort_in_c1: got state %0d expected 5", state);
        end
        tick(0, 1, 4'h1, 0, 0);
        n_checks++;
        if (state !== 3'd0 || Error !== 1'b1 || Done !== 1'b0) begin
            n_fail++; $display("FAIL abort_pulse: got state %0d err %b done %b expected 0 1 0", state, Error, Done);
        end
        tick(1, 0, 4'h0, 0, 0);
        tick(0, 0, 4'h0, 0, 0);
        n_checks++;
        if ({state, Busy, Done, Error} !== 6'b0) begin
            n_fail++; $display("FAIL prog_locked: got %b expected %b", {state, Busy, Done, Error}, 6'b0);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 4'h0, 1, 0);
        tick(0, 1, 4'h9, 1, 0); tick(0, 1, 4'hA, 1, 0); tick(0, 1, 4'hB, 1, 0);
        tick(0, 1, 4'h9, 1, 0); tick(0, 1, 4'hA, 1, 0);
        n_checks++;
        if (state !== 3'd6) begin
            n_fail++; $display("FAIL rst_mid_c2: got state %0d expected 6", state);
        end
        tick(0, 1, 4'hB, 1, 1);
        n_checks++;
        if ({Code0, Code1, Code2} !== 12'b1101_0111_1001 || state !== 3'd0 || Done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got codes %h state %0d done %b expected d79 0 0",
                               {Code0, Code1, Code2}, state, Done);
        end
        tick(0, 0, 4'h0, 1, 0);
        n_checks++;
        if (Done !== 1'b0 || {Code0, Code1, Code2} !== 12'b1101_0111_1001) begin
            n_fail++; $display("FAIL rst_mid_after: got done %b codes %h expected 0 d79", Done, {Code0, Code1, Code2});
        end
    endtask

    task automatic test_back_to_back_prog();
        tick(1, 0, 4'h0, 1, 0);
        tick(0, 1, 4'h2, 1, 0);
        tick(1, 0, 4'h0, 1, 0);
        n_checks++;
        if (state !== 3'd2 || Error !== 1'b0) begin
            n_fail++; $display("FAIL busy_prog: got state %0d err %b expected 2 0", state, Error);
        end
        tick(0, 1, 4'h3, 1, 0);
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++; $display("FAIL busy_prog_next: got state %0d expected 3", state);
        end
        tick(0, 0, 4'h0, 0, 0);
    endtask

    task automatic test_random();
        logic p, e, u, r;
        logic [3:0] pw;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            u  = ($urandom_range(0, 39) != 0);
            pw = 4'($urandom_range(0, 15));
            if (m_phase == 0) begin
                p = ($urandom_range(0, 2) == 0);
                e = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 7) == 0);
                e = ($urandom_range(0, 1) == 0);
                if (m_phase >= 4 && m_phase <= 6 && $urandom_range(0, 3) != 0) pw = m_ent[m_phase-4];
            end
            tick(p, e, pw, u, r);
            n_checks++;
            if (state !== 3'(m_phase)) begin
                n_fail++; $display("FAIL rand_state cyc %0d: got %0d expected %0d", c, state, m_phase);
            end
            n_checks++;
            if (Busy !== (m_phase != 0)) begin
                n_fail++; $display("FAIL rand_busy cyc %0d: got %b expected %b", c, Busy, m_phase != 0);
            end
            n_checks++;
            if (Done !== m_done || Error !== m_err) begin
                n_fail++; $display("FAIL rand_pulse cyc %0d: got done %b err %b expected %b %b", c, Done, Error, m_done, m_err);
            end
            n_checks++;
            if ({Code0, Code1, Code2} !== {m_code[0], m_code[1], m_code[2]}) begin
                n_fail++; $display("FAIL rand_codes cyc %0d: got %h expected %h", c, {Code0, Code1, Code2},
                                   {m_code[0], m_code[1], m_code[2]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_mismatch();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back_prog();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
